fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the 32-bit PC register.
- Accepts a PC over a valid/ready handshake and issues a request/grant/response transaction to instruction memory.
- Holds the fetched word and presents {instruction, PC} to decode over a valid/ready handshake.
- Handles flush/redirect and misaligned PCs; one fetch in flight.

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage placed after the PC register. Takes one PC at a
//   time, fetches the word from instruction memory with a req/gnt request
//   followed by an rvalid response, and hands {instruction, PC} to decode.
//   Misaligned PCs never reach memory; they deliver NOP_INSTR with
//   misaligned_o set. A flush cancels the fetch in progress. If the grant
//   was already taken, the unit waits for the stale response and drops it.
//
// Optional feature (macro FETCH_BYPASS_EN):
//   When defined, a response arriving in WAIT is presented to decode in the
//   same cycle. If decode accepts in that cycle, the OUT state is skipped.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The PC side uses pc_valid_i/pc_ready_o and the decode side
//   uses instr_valid_o/instr_ready_i. Memory requests are held until
//   imem_gnt_i. Responses are qualified by imem_rvalid_i and are sampled
//   only in WAIT and DRAIN.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   pc_i/pc_valid_i/pc_ready_o  PC input handshake
//   flush_i                  drop the current fetch (redirect)
//   imem_req_o/imem_addr_o/imem_gnt_i  memory request channel
//   imem_rvalid_i/imem_rdata_i         memory response channel
//   instr_o/instr_pc_o/instr_valid_o/instr_ready_i/misaligned_o  decode side
//   state_o                  current FSM state (debug visibility)
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic            misaligned_o,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            misaligned_q;
    logic            pc_accept;

    // No PC is taken while reset is asserted, so ready is masked as well.
    assign pc_ready_o  = (state_q == ST_IDLE) && !flush_i && !reset;
    assign pc_accept   = pc_valid_i && pc_ready_o;

    assign imem_req_o  = (state_q == ST_REQ);
    assign imem_addr_o = (state_q == ST_REQ) ? {pc_q[XLEN-1:2], 2'b00} : '0;
    assign instr_pc_o  = pc_q;
    assign state_o     = state_q;

`ifdef FETCH_BYPASS_EN
    logic bypass_valid;
    // The response is forwarded straight to decode unless it is being flushed.
    assign bypass_valid  = (state_q == ST_WAIT) && imem_rvalid_i && !flush_i;
    assign instr_valid_o = (state_q == ST_OUT) || bypass_valid;
    assign instr_o       = bypass_valid ? imem_rdata_i : instr_q;
`else
    assign instr_valid_o = (state_q == ST_OUT);
    assign instr_o       = instr_q;
`endif

    // misaligned_q is cleared on every aligned accept, so it is 0 during bypass.
    assign misaligned_o = instr_valid_o && misaligned_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            instr_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pc_accept) begin
                        pc_q <= pc_i;
                        if (pc_i[1:0] == 2'b00) begin
                            misaligned_q <= 1'b0;
                            state_q      <= ST_REQ;
                        end else begin
                            instr_q      <= NOP_INSTR;
                            misaligned_q <= 1'b1;
                            state_q      <= ST_OUT;
                        end
                    end
                end
                ST_REQ: begin
                    // A grant that coincides with a flush still owes us a response.
                    if (flush_i) begin
                        state_q <= imem_gnt_i ? ST_DRAIN : ST_IDLE;
                    end else if (imem_gnt_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        state_q <= imem_rvalid_i ? ST_IDLE : ST_DRAIN;
                    end else if (imem_rvalid_i) begin
                        instr_q      <= imem_rdata_i;
                        misaligned_q <= 1'b0;
`ifdef FETCH_BYPASS_EN
                        state_q      <= instr_ready_i ? ST_IDLE : ST_OUT;
`else
                        state_q      <= ST_OUT;
`endif
                    end
                end
                ST_OUT: begin
                    if (flush_i || instr_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // The stale response is discarded. A flush here changes nothing.
                    if (imem_rvalid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Bench for fetch_unit. It contains a responding instruction memory and a
//   transaction-level reference model. The model tracks whether a fetch is
//   live, whether its grant was taken, and how many memory responses are
//   still owed. From that it predicts every output in every cycle. Directed
//   sequences pin the model with literal values.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        misaligned_o;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i), .misaligned_o(misaligned_o),
        .state_o(state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model settings.
    bit          rand_mode      = 1'b0;
    int          fixed_gnt_wait = 0;
    int          fixed_rv_wait  = 0;
    int          gnt_hold       = 0;
    bit          mem_busy       = 1'b0;
    int          mem_wait       = 0;
    logic [31:0] mem_addr       = '0;

    // Reference model state.
    bit          m_busy    = 1'b0;
    bit          m_granted = 1'b0;
    bit          m_dv      = 1'b0;
    bit          m_mis     = 1'b0;
    int          m_owed    = 0;
    logic [31:0] m_pc      = '0;
    logic [31:0] m_instr   = '0;

    // Predictions and samples for the current cycle.
    bit          e_ready, e_req, e_valid, e_byp;
    logic        s_req;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h00A0_0093;
            32'h0000_0200: return 32'h0000_0013;
            32'h0000_0300: return 32'hDEAD_BEEF;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Compare the DUT with the model in the middle of the cycle.
    task automatic compare();
        e_ready = !reset && !m_busy && (m_owed == 0) && !flush_i;
        e_req   = m_busy && !m_granted && !m_dv;
`ifdef FETCH_BYPASS_EN
        e_byp   = m_busy && m_granted && !m_dv && (m_owed > 0) && imem_rvalid_i && !flush_i;
`else
        e_byp   = 1'b0;
`endif
        e_valid = (m_busy && m_dv) || e_byp;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        chk1("pc_ready", pc_ready_o, e_ready);
        chk1("imem_req", imem_req_o, e_req);
        if (e_req) chk("imem_addr", imem_addr_o, m_pc);
        chk1("instr_valid", instr_valid_o, e_valid);
        if (e_valid) begin
            chk("instr", instr_o, m_dv ? m_instr : mem_word(m_pc));
            chk("instr_pc", instr_pc_o, m_pc);
            chk1("misaligned", misaligned_o, m_dv && m_mis);
        end
    endtask

    // Drive the inputs for one cycle at the falling edge, then compare.
    task automatic drive(input bit rst, input bit fl, input bit pv,
                         input logic [31:0] p, input bit rdy);
        @(negedge clk);
        reset         = rst;
        flush_i       = fl;
        pc_valid_i    = pv;
        pc_i          = p;
        instr_ready_i = rdy;
        imem_gnt_i    = 1'b0;
        if (imem_req_o)
            imem_gnt_i = rand_mode ? ($urandom_range(0, 2) == 0) : (gnt_hold >= fixed_gnt_wait);
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (mem_busy) begin
            if (mem_wait == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(mem_addr);
            end
        end else if (rand_mode && $urandom_range(0, 7) == 0) begin
            imem_rvalid_i = 1'b1;
        end
        #1;
        compare();
    endtask

    // Rising edge: advance the memory and the reference model.
    task automatic tick();
        bit hs, acc, g, rsp;
        @(posedge clk);
        hs  = e_valid && instr_ready_i;
        acc = e_ready && pc_valid_i;
        g   = e_req && imem_gnt_i;
        rsp = (m_owed > 0) && imem_rvalid_i;
        if (mem_busy) begin
            if (imem_rvalid_i) mem_busy = 1'b0;
            else mem_wait--;
        end
        if (s_req && imem_gnt_i) begin
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_wait = rand_mode ? $urandom_range(0, 3) : fixed_rv_wait;
            gnt_hold = 0;
        end else if (s_req) begin
            gnt_hold++;
        end else begin
            gnt_hold = 0;
        end
        if (reset) begin
            m_busy = 0; m_granted = 0; m_dv = 0; m_mis = 0; m_owed = 0;
        end else begin
            if (rsp) begin
                m_owed--;
                if (m_busy && !flush_i) begin
                    m_dv = 1; m_mis = 0; m_instr = mem_word(m_pc);
                end
            end
            if (g) begin
                m_owed++;
                m_granted = 1;
            end
            if (flush_i || hs) begin
                m_busy = 0;
                m_dv   = 0;
            end
            if (acc) begin
                m_busy = 1; m_pc = pc_i; m_granted = 0;
                if (pc_i[1:0] != 2'b00) begin
                    m_dv = 1; m_mis = 1; m_instr = NOP;
                end else begin
                    m_dv = 0; m_mis = 0;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit fl, input bit pv,
                        input logic [31:0] p, input bit rdy);
        drive(rst, fl, pv, p, rdy);
        tick();
    endtask

    initial begin
        bit          got;
        logic [31:0] p;
        reset = 1'b1; flush_i = 1'b0; pc_valid_i = 1'b0; pc_i = '0;
        instr_ready_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        repeat (2) @(posedge clk);

        // Reset state.
        drive(1, 0, 1, 32'h100, 1);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_instr_pc", instr_pc_o, 32'h0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk1("rst_mis", misaligned_o, 1'b0);
        tick();

        // Best-case fetch of 0x100.
        drive(0, 0, 1, 32'h100, 1);
        chk1("t1_ready_c0", pc_ready_o, 1'b1);
        tick();
        drive(0, 0, 0, 32'h0, 1);
        chk1("t1_req_c1", imem_req_o, 1'b1);
        chk("t1_addr_c1", imem_addr_o, 32'h100);
        tick();
        drive(0, 0, 0, 32'h0, 1);
`ifdef FETCH_BYPASS_EN
        chk1("t1_valid_c2", instr_valid_o, 1'b1);
        chk("t1_instr_c2", instr_o, 32'h00A0_0093);
`else
        chk1("t1_valid_c2", instr_valid_o, 1'b0);
`endif
        tick();
        drive(0, 0, 0, 32'h0, 1);
`ifdef FETCH_BYPASS_EN
        chk1("t1_ready_c3", pc_ready_o, 1'b1);
`else
        chk1("t1_valid_c3", instr_valid_o, 1'b1);
        chk("t1_instr_c3", instr_o, 32'h00A0_0093);
        chk("t1_pc_c3", instr_pc_o, 32'h100);
`endif
        tick();
        step(0, 0, 0, 32'h0, 0);

        // Grant held off for 3 cycles, decode stalled for 2 cycles.
        fixed_gnt_wait = 3;
        step(0, 0, 1, 32'h100, 0);
        for (int c = 1; c <= 4; c++) begin
            drive(0, 0, 0, 32'h0, 0);
            chk1("t2_req", imem_req_o, 1'b1);
            chk("t2_addr", imem_addr_o, 32'h100);
            tick();
        end
        fixed_gnt_wait = 0;
        step(0, 0, 0, 32'h0, 0);
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 32'h0, c == 2);
            chk1("t2_valid", instr_valid_o, 1'b1);
            chk("t2_instr", instr_o, 32'h00A0_0093);
            chk1("t2_ready_low", pc_ready_o, 1'b0);
            tick();
        end
        drive(0, 0, 0, 32'h0, 0);
        chk1("t2_ready_after", pc_ready_o, 1'b1);
        tick();

        // Misaligned PC.
        step(0, 0, 1, 32'h102, 0);
        drive(0, 0, 0, 32'h0, 1);
        chk1("t3_req", imem_req_o, 1'b0);
        chk1("t3_valid", instr_valid_o, 1'b1);
        chk("t3_instr", instr_o, NOP);
        chk1("t3_mis", misaligned_o, 1'b1);
        chk("t3_pc", instr_pc_o, 32'h102);
        tick();

        // Flush in WAIT; the late DEADBEEF response must be dropped.
        fixed_rv_wait = 2;
        step(0, 0, 1, 32'h300, 1);
        for (int c = 1; c <= 4; c++) begin
            drive(0, c == 2, 0, 32'h0, 1);
            chk1("t4_no_valid", instr_valid_o, 1'b0);
            if (c >= 3) chk1("t4_drain_ready", pc_ready_o, 1'b0);
            tick();
        end
        fixed_rv_wait = 0;
        drive(0, 0, 1, 32'h200, 1);
        chk1("t4_ready_c5", pc_ready_o, 1'b1);
        tick();
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            drive(0, 0, 0, 32'h0, 1);
            if (instr_valid_o) begin
                got = 1'b1;
                chk("t4_instr", instr_o, 32'h0000_0013);
                chk("t4_pc", instr_pc_o, 32'h200);
                chk1("t4_mis", misaligned_o, 1'b0);
            end
            tick();
        end
        chk1("t4_delivered", got, 1'b1);

        // Reset during REQ with the response arriving after it.
        step(0, 0, 1, 32'h100, 1);
        step(1, 0, 0, 32'h0, 1);
        drive(1, 0, 0, 32'h0, 1);
        chk("t5_state", 32'(state_o), 32'd0);
        chk1("t5_req", imem_req_o, 1'b0);
        chk1("t5_valid", instr_valid_o, 1'b0);
        chk1("t5_pc_ready", pc_ready_o, 1'b0);
        tick();
        drive(0, 0, 0, 32'h0, 1);
        chk1("t5_ready_after", pc_ready_o, 1'b1);
        tick();
        for (int c = 0; c < 4; c++) step(0, 0, 0, 32'h0, 1);

        // Randomized traffic.
        rand_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            p = $urandom;
            if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0,
                 1'($urandom_range(0, 1)), p, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
